sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_arb_id_fifo.sv | 62 ++++++
 rtl/sdram_port_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the two-master SDRAM port arbiter.
// Round-robin arbitration is enabled by defining SDRAM_ARB_RR_EN.
package sdram_arb_pkg;

    localparam int NUM_MASTERS    = 2;
    localparam int MID_W          = 1;
    localparam int DEF_ADDR_WIDTH = 25;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_RD_DEPTH   = 4;

    typedef logic [MID_W-1:0] mid_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD_WR = 2'd1,
        ST_CMD_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// FIFO of master IDs for reads issued to the controller, in issue order.
// The head tells the return path which master owns the next read beat.
module sdram_arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = DEF_RD_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  mid_t push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output mid_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    mid_t             id_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    // A push while full is dropped even if a pop happens in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = id_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            id_mem[wr_ptr_reg] <= push_id;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master AXI-lite style arbiter in front of a single SDRAM controller port.
// Fixed master-0 priority by default; round-robin when SDRAM_ARB_RR_EN is defined.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_DEPTH   = DEF_RD_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_axi_araddr,
    input  logic                  m0_axi_arvalid,
    output logic                  m0_axi_arready,
    output logic [DATA_WIDTH-1:0] m0_axi_rdata,
    output logic                  m0_axi_rvalid,
    input  logic                  m0_axi_rready,
    input  logic [ADDR_WIDTH-1:0] m0_axi_awaddr,
    input  logic                  m0_axi_awvalid,
    output logic                  m0_axi_awready,
    input  logic [DATA_WIDTH-1:0] m0_axi_wdata,
    input  logic                  m0_axi_wvalid,
    output logic                  m0_axi_wready,
    input  logic [ADDR_WIDTH-1:0] m1_axi_araddr,
    input  logic                  m1_axi_arvalid,
    output logic                  m1_axi_arready,
    output logic [DATA_WIDTH-1:0] m1_axi_rdata,
    output logic                  m1_axi_rvalid,
    input  logic                  m1_axi_rready,
    input  logic [ADDR_WIDTH-1:0] m1_axi_awaddr,
    input  logic                  m1_axi_awvalid,
    output logic                  m1_axi_awready,
    input  logic [DATA_WIDTH-1:0] m1_axi_wdata,
    input  logic                  m1_axi_wvalid,
    output logic                  m1_axi_wready,
    output logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    input  logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    output logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    output logic                  s_axi_awvalid,
    input  logic                  s_axi_awready,
    output logic [DATA_WIDTH-1:0] s_axi_wdata,
    output logic                  s_axi_wvalid,
    input  logic                  s_axi_wready,
    output logic                  rd_orphan
);

    logic [ADDR_WIDTH-1:0]  araddr_a [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0]  awaddr_a [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  wdata_a  [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] arvalid_v, awvalid_v, wvalid_v, rready_v;
    logic [NUM_MASTERS-1:0] arready_v, awready_v, wready_v, rvalid_v;
    logic [NUM_MASTERS-1:0] wr_req, rd_req, req_any;

    arb_state_t state_reg, state_next;
    mid_t       grant_reg, grant_next;
    mid_t       pick_id;
    logic       wr_fire, rd_fire, rd_pop;
    logic       fifo_full, fifo_empty;
    mid_t       fifo_head;
    logic       rd_orphan_reg;

    assign araddr_a[0] = m0_axi_araddr;
    assign araddr_a[1] = m1_axi_araddr;
    assign awaddr_a[0] = m0_axi_awaddr;
    assign awaddr_a[1] = m1_axi_awaddr;
    assign wdata_a[0]  = m0_axi_wdata;
    assign wdata_a[1]  = m1_axi_wdata;
    assign arvalid_v   = {m1_axi_arvalid, m0_axi_arvalid};
    assign awvalid_v   = {m1_axi_awvalid, m0_axi_awvalid};
    assign wvalid_v    = {m1_axi_wvalid, m0_axi_wvalid};
    assign rready_v    = {m1_axi_rready, m0_axi_rready};

    assign m0_axi_arready = arready_v[0];
    assign m1_axi_arready = arready_v[1];
    assign m0_axi_awready = awready_v[0];
    assign m1_axi_awready = awready_v[1];
    assign m0_axi_wready  = wready_v[0];
    assign m1_axi_wready  = wready_v[1];
    assign m0_axi_rvalid  = rvalid_v[0];
    assign m1_axi_rvalid  = rvalid_v[1];
    assign m0_axi_rdata   = s_axi_rdata;
    assign m1_axi_rdata   = s_axi_rdata;

    // Reads are held off while every ID slot is in use.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign wr_req[gi]   = awvalid_v[gi] & wvalid_v[gi];
            assign rd_req[gi]   = arvalid_v[gi] & ~fifo_full;
            assign req_any[gi]  = wr_req[gi] | rd_req[gi];
            assign rvalid_v[gi] = s_axi_rvalid & ~fifo_empty & (fifo_head == mid_t'(gi));
        end
    endgenerate

`ifdef SDRAM_ARB_RR_EN
    mid_t rr_ptr_reg;

    // rr_ptr_reg names the master that wins a tie; the winner is demoted.
    always_comb begin
        pick_id = req_any[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else if (state_reg == ST_IDLE && (|req_any)) begin
            rr_ptr_reg <= ~pick_id;
        end
    end
`else
    always_comb begin
        pick_id = req_any[0] ? mid_t'(0) : mid_t'(1);
    end
`endif

    assign wr_fire = s_axi_awvalid & s_axi_awready & s_axi_wvalid & s_axi_wready;
    assign rd_fire = s_axi_arvalid & s_axi_arready;
    assign rd_pop  = s_axi_rvalid & s_axi_rready & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req_any) begin
                    grant_next = pick_id;
                    state_next = wr_req[pick_id] ? ST_CMD_WR : ST_CMD_RD;
                end
            end
            ST_CMD_WR: if (wr_fire) state_next = ST_IDLE;
            ST_CMD_RD: if (rd_fire) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axi_araddr  = araddr_a[grant_reg];
        s_axi_awaddr  = awaddr_a[grant_reg];
        s_axi_wdata   = wdata_a[grant_reg];
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        arready_v     = '0;
        awready_v     = '0;
        wready_v      = '0;
        case (state_reg)
            ST_CMD_WR: begin
                s_axi_awvalid        = awvalid_v[grant_reg];
                s_axi_wvalid         = wvalid_v[grant_reg];
                awready_v[grant_reg] = s_axi_awready;
                wready_v[grant_reg]  = s_axi_wready;
            end
            ST_CMD_RD: begin
                s_axi_arvalid        = arvalid_v[grant_reg];
                arready_v[grant_reg] = s_axi_arready;
            end
            default: ;
        endcase
    end

    // With nothing outstanding, stray read data is accepted and dropped.
    assign s_axi_rready = fifo_empty ? s_axi_rvalid : rready_v[fifo_head];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_orphan_reg <= 1'b0;
        end else if (s_axi_rvalid && fifo_empty) begin
            rd_orphan_reg <= 1'b1;
        end
    end

    assign rd_orphan = rd_orphan_reg;

    sdram_arb_id_fifo #(
        .DEPTH(RD_DEPTH)
    ) u_id_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (rd_fire),
        .push_id(grant_reg),
        .pop    (rd_pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

endmodule
